// File: rtl/subkey_demux_16_if.sv
// Handshake and slot bus between the key schedule side and subkey_demux_16.
// The master drives subkeys in; the slave presents all 16 stored slots.
interface subkey_demux_16_if #(
  parameter int unsigned WIDTH = 48
);
  logic                  start;
  logic                  decrypt;
  logic                  in_valid;
  logic [WIDTH-1:0]      in_data;
  logic                  in_ready;
  logic [15:0]           slot_wr_en;
  logic [4:0]            wr_count;
  logic [16*WIDTH-1:0]   keys_flat;
  logic                  busy;
  logic                  loaded;

  modport master (
    output start, decrypt, in_valid, in_data,
    input  in_ready, slot_wr_en, wr_count, keys_flat, busy, loaded
  );

  modport slave (
    input  start, decrypt, in_valid, in_data,
    output in_ready, slot_wr_en, wr_count, keys_flat, busy, loaded
  );
endinterface

// File: rtl/subkey_demux_16.sv
// Routes a stream of 16 DES round subkeys into 16 parallel slots, ascending
// for encryption and descending for decryption, so slot r always holds round r.
module subkey_demux_16 #(
  parameter int unsigned WIDTH = 48
) (
  input logic               clk,
  input logic               rst,
  subkey_demux_16_if.slave  bus
);
  localparam int unsigned NSLOT = 16;
  localparam int unsigned CW    = 5;
  localparam int unsigned IW    = 4;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic              dir;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  slots [NSLOT];
  logic              busy_q;
  logic              loaded_q;
  logic              ready;
  logic              accept;
  logic [IW-1:0]     idx;
  logic [NSLOT-1:0]  wr_en;

  // State register; busy/loaded are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state    <= state_next;
      busy_q   <= (state_next == LOAD);
      loaded_q <= (state_next == DONE);
    end
  end

  // Next state: start restarts from any state; the 16th accept completes.
  always_comb begin
    state_next = state;
    if (bus.start) begin
      state_next = LOAD;
    end else if (state == LOAD && accept && count == CW'(NSLOT - 1)) begin
      state_next = DONE;
    end
  end

  // Combinational handshake and one-hot slot strobe.
  always_comb begin
    ready  = 1'b0;
    accept = 1'b0;
    idx    = '0;
    wr_en  = '0;
    ready  = (state == LOAD) && !bus.start;
    accept = ready && bus.in_valid;
    idx    = dir ? (IW'(NSLOT - 1) - count[IW-1:0]) : count[IW-1:0];
    if (accept) begin
      wr_en = NSLOT'(1) << idx;
    end
  end

  // Beat counter, latched direction and slot storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      dir   <= 1'b0;
      for (int k = 0; k < NSLOT; k++) begin
        slots[k] <= '0;
      end
    end else if (bus.start) begin
      count <= '0;
      dir   <= bus.decrypt;
    end else if (accept) begin
      count      <= count + CW'(1);
      slots[idx] <= bus.in_data;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.slot_wr_en = wr_en;
  assign bus.wr_count   = count;
  assign bus.busy       = busy_q;
  assign bus.loaded     = loaded_q;

  for (genvar k = 0; k < NSLOT; k++) begin : g_flat
    assign bus.keys_flat[k*WIDTH +: WIDTH] = slots[k];
  end
endmodule

// File: tb/tb_subkey_demux_16.sv
// Self-checking bench for subkey_demux_16: per-cycle compare against a
// behavioural load model, plus literal checks for the directed scenarios.
module tb_subkey_demux_16;
  localparam int unsigned W = 48;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  subkey_demux_16_if #(.WIDTH(W)) bus ();
  subkey_demux_16 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // Behavioural model: a load has "started" and has taken m_count beats.
  logic [W-1:0] m_slot [16];
  int           m_count;
  bit           m_started;
  bit           m_dir;
  bit           m_valid = 1'b0;

  function automatic bit m_ready();
    return m_started && (m_count < 16) && !bus.start;
  endfunction

  function automatic int m_index();
    return m_dir ? 15 - m_count : m_count;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] slot_of(input int k);
    return bus.keys_flat[k*W +: W];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) m_slot[k] = '0;
      m_count   = 0;
      m_started = 1'b0;
      m_dir     = 1'b0;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      if (bus.start) begin
        m_started = 1'b1;
        m_count   = 0;
        m_dir     = bus.decrypt;
      end else if (bus.in_valid && m_ready()) begin
        m_slot[m_index()] = bus.in_data;
        m_count++;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [15:0] exp_en;
      exp_en = '0;
      if (bus.in_valid && m_ready()) exp_en = 16'(1) << m_index();
      chk("in_ready", 64'(bus.in_ready), 64'(m_ready()));
      chk("slot_wr_en", 64'(bus.slot_wr_en), 64'(exp_en));
      chk("wr_count", 64'(bus.wr_count), 64'(m_count));
      chk("busy", 64'(bus.busy), 64'(m_started && m_count < 16));
      chk("loaded", 64'(bus.loaded), 64'(m_started && m_count == 16));
      for (int k = 0; k < 16; k++) chk("slot", 64'(slot_of(k)), 64'(m_slot[k]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.decrypt  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic pulse_start(input bit dec);
    bus.start   = 1'b1;
    bus.decrypt = dec;
    tick();
    bus.start   = 1'b0;
    bus.decrypt = 1'b0;
  endtask

  logic [W-1:0] acc_q [$];

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_keys_zero", 64'(bus.keys_flat == '0), 64'd1);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    tick();

    // Encrypt fill: slot k gets k, strobe 1<<k, loaded after the 16th edge.
    pulse_start(1'b0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.in_data = W'(k);
      @(negedge clk);
      chk("enc_wr_en", 64'(bus.slot_wr_en), 64'(16'(1) << k));
      if (k == 15) chk("enc_loaded_early", 64'(bus.loaded), 64'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("enc_loaded", 64'(bus.loaded), 64'd1);
    chk("enc_busy", 64'(bus.busy), 64'd0);
    chk("enc_count", 64'(bus.wr_count), 64'd16);
    for (int k = 0; k < 16; k++) chk("enc_slot", 64'(slot_of(k)), 64'(k));
    tick();

    // Decrypt fill: slot 15-k gets A0+k, first strobe is the top slot.
    pulse_start(1'b1);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.in_data = W'(48'hA0 + k);
      if (k == 0) begin
        @(negedge clk);
        chk("dec_first_wr_en", 64'(bus.slot_wr_en), 64'h8000);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 16; k++) chk("dec_slot", 64'(slot_of(15 - k)), 64'(48'hA0 + k));

    // Overrun in DONE: nothing accepted, slots untouched.
    bus.in_valid = 1'b1;
    bus.in_data  = 48'hFFFF_FFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      chk("ovr_in_ready", 64'(bus.in_ready), 64'd0);
      chk("ovr_wr_en", 64'(bus.slot_wr_en), 64'd0);
    end
    for (int k = 0; k < 16; k++) chk("ovr_slot", 64'(slot_of(15 - k)), 64'(48'hA0 + k));
    bus.in_valid = 1'b0;
    tick();

    // Backpressure: random ~50% valid, ascending order, no loss/duplication.
    pulse_start(1'b0);
    begin
      int cyc;
      cyc = 0;
      while (m_count < 16 && cyc < 300) begin
        bus.in_valid = ($urandom_range(1, 0) == 1);
        bus.in_data  = W'({$urandom(), $urandom()});
        if (bus.in_valid && m_ready()) acc_q.push_back(bus.in_data);
        tick();
        cyc++;
      end
      chk("bp_timeout", 64'(cyc < 300), 64'd1);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepts", 64'(acc_q.size()), 64'd16);
    for (int k = 0; k < 16 && k < acc_q.size(); k++) chk("bp_slot", 64'(slot_of(k)), 64'(acc_q[k]));
    tick();

    // Restart after 7 ascending beats with a decrypt start that carries a beat.
    pulse_start(1'b0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      bus.in_data = W'(48'h100 + k);
      tick();
    end
    bus.start   = 1'b1;
    bus.decrypt = 1'b1;
    bus.in_data = W'(48'h999);
    @(negedge clk);
    chk("rs_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rs_wr_en", 64'(bus.slot_wr_en), 64'd0);
    tick();
    bus.start   = 1'b0;
    bus.decrypt = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.in_data = W'(48'h200 + k);
      @(negedge clk);
      if (k == 0) chk("rs_first_wr_en", 64'(bus.slot_wr_en), 64'h8000);
      if (k == 1) for (int j = 0; j < 7; j++) chk("rs_keep", 64'(slot_of(j)), 64'(48'h100 + j));
      chk("rs_loaded_low", 64'(bus.loaded), 64'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rs_loaded", 64'(bus.loaded), 64'd1);
    chk("rs_slot15", 64'(slot_of(15)), 64'(48'h200));
    tick();

    // Reset mid-LOAD after 5 beats.
    pulse_start(1'b0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.in_data = W'(48'h300 + k);
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_keys", 64'(bus.keys_flat == '0), 64'd1);
    chk("mrst_count", 64'(bus.wr_count), 64'd0);
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_loaded", 64'(bus.loaded), 64'd0);
    chk("mrst_in_ready", 64'(bus.in_ready), 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
